// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Byte type, default sizes, instruction lengths and fetch FSM states.
package instr_fetch_queue_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEF_WORD_WIDTH  = 32;
    localparam int DEF_FETCH_BYTES = 4;
    localparam int DEF_BUF_BYTES   = 16;

    localparam int IMAX        = 1 + DEF_WORD_WIDTH / 8;
    localparam int FETCH_LOG2  = $clog2(DEF_FETCH_BYTES);
    localparam int BUF_LOG2    = $clog2(DEF_BUF_BYTES);

    localparam int LEN_1    = 1;
    localparam int LEN_2    = 2;
    localparam int LEN_3    = 3;
    localparam int LEN_5    = 5;
    localparam int LEN_IMAX = IMAX;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic int imax_of(input int word_width);
        return 1 + word_width / 8;
    endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte buffer: push 0..FETCH_BYTES, pop 0..WIN_BYTES, flush.
// Ports: push_len/push_data in, pop_len in, flush in, count/head out.
module fetch_byte_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int FETCH_BYTES = DEF_FETCH_BYTES,
    parameter int BUF_BYTES   = DEF_BUF_BYTES,
    parameter int WIN_BYTES   = IMAX,
    localparam int PTR_W  = $clog2(BUF_BYTES),
    localparam int CNT_W  = PTR_W + 1,
    localparam int PUSH_W = $clog2(FETCH_BYTES + 1),
    localparam int POP_W  = $clog2(WIN_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [PUSH_W-1:0]        push_len,
    input  logic [8*FETCH_BYTES-1:0] push_data,
    input  logic [POP_W-1:0]         pop_len,
    output logic [CNT_W-1:0]         count,
    output logic [8*WIN_BYTES-1:0]   head
);

    byte_t            store [BUF_BYTES];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                if (PUSH_W'(k) < push_len) begin
                    store[wr_ptr + PTR_W'(k)] <= push_data[8*k +: 8];
                end
            end
            wr_ptr <= wr_ptr + PTR_W'(push_len);
            rd_ptr <= rd_ptr + PTR_W'(pop_len);
            count  <= count + CNT_W'(push_len) - CNT_W'(pop_len);
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            head[8*i +: 8] = store[rd_ptr + PTR_W'(i)];
        end
    end

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!reset_n)
        !flush |-> (32'(count) + 32'(push_len) <= BUF_BYTES)
    );

    a_no_underflow : assert property (
        @(posedge clk) disable iff (!reset_n)
        !flush |-> (32'(pop_len) <= 32'(count))
    );

endmodule

// File: rtl/instr_fetch_queue.sv
// Byte-stream instruction prefetcher feeding decode.
// Ports: mem_* fetch bus, instr_valid/instruction/immediate/pc to
// decode, consume/consume_len pop, redirect/redirect_pc flush.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int WORD_WIDTH         = DEF_WORD_WIDTH,
    parameter int PROGRAM_ADDR_WIDTH = 16,
    parameter int FETCH_BYTES        = DEF_FETCH_BYTES,
    parameter int BUF_BYTES          = DEF_BUF_BYTES,
    parameter int RESET_PC           = 0,
    localparam int ILEN  = imax_of(WORD_WIDTH),
    localparam int LEN_W = $clog2(ILEN + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          mem_req,
    output logic [PROGRAM_ADDR_WIDTH-1:0] mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [8*FETCH_BYTES-1:0]      mem_rdata,
    output logic                          instr_valid,
    output logic [7:0]                    instruction,
    output logic [WORD_WIDTH-1:0]         immediate,
    output logic [PROGRAM_ADDR_WIDTH-1:0] pc,
    input  logic                          consume,
    input  logic [LEN_W-1:0]              consume_len,
    input  logic                          redirect,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] redirect_pc
);

    localparam int PAW    = PROGRAM_ADDR_WIDTH;
    localparam int SKIP_W = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
    localparam int CNT_W  = $clog2(BUF_BYTES) + 1;
    localparam int PUSH_W = $clog2(FETCH_BYTES + 1);

    localparam logic [PAW-1:0]   ALIGN     = ~PAW'(FETCH_BYTES - 1);
    localparam logic [PAW-1:0]   PC0       = PAW'(RESET_PC);
    localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(BUF_BYTES - FETCH_BYTES);
    localparam logic [CNT_W-1:0] VALID_MIN = CNT_W'(ILEN);

    logic [1:0]             state;
    logic [1:0]             state_d;
    logic                   discard;
    logic [PAW-1:0]         fetch_addr;
    logic [PAW-1:0]         fetch_addr_d;
    logic [PAW-1:0]         req_addr;
    logic [PAW-1:0]         pc_q;
    logic [SKIP_W-1:0]      skip;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_nx;
    logic [8*ILEN-1:0]      head;
    logic                   take;
    logic                   push_en;
    logic                   pop_en;
    logic                   can_issue;
    logic [PUSH_W-1:0]      push_len;
    logic [LEN_W-1:0]       pop_len;
    logic [8*FETCH_BYTES-1:0] push_data;

    // A response is taken whenever rvalid arrives in WAIT; it only
    // lands in the queue if nothing has invalidated the stream.
    assign take      = (state == ST_WAIT) && mem_rvalid;
    assign push_en   = take && !discard && !redirect;
    assign push_len  = push_en
                     ? PUSH_W'(FETCH_BYTES) - PUSH_W'(skip)
                     : '0;
    assign push_data = mem_rdata >> {skip, 3'b000};

    assign pop_en  = consume && instr_valid && !redirect;
    assign pop_len = pop_en ? consume_len : '0;

    // Issue decision looks at the occupancy the request will see.
    assign count_nx  = redirect ? '0
                     : count + CNT_W'(push_len) - CNT_W'(pop_len);
    assign can_issue = count_nx <= ISSUE_MAX;

    assign fetch_addr_d = redirect ? (redirect_pc & ALIGN) : fetch_addr;

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (can_issue) state_d = ST_REQ;
            ST_REQ:  if (mem_gnt) state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = can_issue ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            discard    <= 1'b0;
            fetch_addr <= PC0 & ALIGN;
            req_addr   <= PC0 & ALIGN;
            skip       <= PC0[SKIP_W-1:0];
            pc_q       <= PC0;
        end else begin
            state <= state_d;
            if (state_d == ST_REQ && state != ST_REQ) begin
                req_addr <= fetch_addr_d;
            end
            if (redirect) begin
                fetch_addr <= redirect_pc & ALIGN;
                skip       <= redirect_pc[SKIP_W-1:0];
                pc_q       <= redirect_pc;
            end else begin
                // A discarded grant belongs to the old stream; the
                // new fetch address was already loaded by redirect.
                if (state == ST_REQ && mem_gnt && !discard) begin
                    fetch_addr <= fetch_addr + PAW'(FETCH_BYTES);
                end
                if (push_en) begin
                    skip <= '0;
                end
                pc_q <= pc_q + PAW'(pop_len);
            end
            if (take) begin
                discard <= 1'b0;
            end else if (redirect && state != ST_IDLE) begin
                discard <= 1'b1;
            end
        end
    end

    fetch_byte_queue #(
        .FETCH_BYTES (FETCH_BYTES),
        .BUF_BYTES   (BUF_BYTES),
        .WIN_BYTES   (ILEN)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect),
        .push_len  (push_len),
        .push_data (push_data),
        .pop_len   (pop_len),
        .count     (count),
        .head      (head)
    );

    assign mem_req     = (state == ST_REQ);
    assign mem_addr    = req_addr;
    assign instr_valid = count >= VALID_MIN;
    assign instruction = head[7:0];
    assign immediate   = head[8*ILEN-1:8];
    assign pc          = pc_q;

    a_len_legal : assert property (
        @(posedge clk) disable iff (!reset_n)
        (consume && instr_valid) |-> (32'(consume_len) <= ILEN)
    );

endmodule
